// File: rtl/dlx_pkg.sv
// Shared DLX definitions: datapath width, fetch queue entry layout and helpers.
package dlx_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DLX_NOP = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are never meaningful.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage.
module fetch_fifo
  import dlx_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] occupancy,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign occupancy = count_q;
  assign head      = mem[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    // Flush beats any same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// DLX instruction-fetch stage: credit-limited in-order fetch into a prefetch queue,
// with redirect flush and discard of wrong-path responses still in flight.
module if_prefetch
  import dlx_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  input  logic        id_ready
);

  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTST + 1);

  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0]  drop_q, drop_d;
  logic [OCW-1:0]  outst, outst_next;
  logic            grant, resp;
  logic            q_push, q_pop, q_flush;
  logic            q_full, q_empty, resp_full, resp_empty;
  logic [QCW-1:0]  q_occ;
  fetch_entry_t    q_head, q_push_data, resp_head, resp_push_data;
  logic [XLEN-1:0] resp_instr_unused;

  // The resp_pc FIFO's occupancy is the outstanding-request count.
  fetch_fifo #(.DEPTH(MAX_OUTST)) u_resp_pc (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (resp_push_data),
    .pop       (resp),
    .flush     (1'b0),
    .head      (resp_head),
    .occupancy (outst),
    .full      (resp_full),
    .empty     (resp_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .head      (q_head),
    .occupancy (q_occ),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign resp_instr_unused = resp_head.instr;

  // Every outstanding request already owns a queue slot, so rvalid is never back-pressured.
  assign imem_req  = !rst && !resp_full && !q_full &&
                     ((int'(q_occ) + int'(outst)) < DEPTH);
  assign imem_addr = rst ? RESET_PC : fetch_pc_q;

  always_comb begin
    grant          = imem_req && imem_gnt;
    resp           = imem_rvalid && !resp_empty;
    resp_push_data = '{pc: fetch_pc_q, instr: DLX_NOP};
    q_push_data    = '{pc: resp_head.pc, instr: imem_rdata};
    q_push         = resp && (drop_q == '0) && !redirect;
    q_pop          = id_valid && id_ready;
    q_flush        = redirect;
    outst_next     = outst + OCW'(grant) - OCW'(resp);

    fetch_pc_d = fetch_pc_q;
    if (grant) begin
      fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
    end
    drop_d = drop_q;
    if (resp && (drop_q != '0)) begin
      drop_d = drop_q - OCW'(1);
    end
    // Everything still in flight after this cycle, including a grant made now, is wrong-path.
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      drop_d     = outst_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  assign id_valid    = !rst && !q_empty;
  assign id_instr    = id_valid ? q_head.instr : '0;
  assign id_pc       = id_valid ? q_head.pc : '0;
  assign id_pc_plus4 = id_pc + 32'd4;

endmodule

// File: tb/tb_if_prefetch.sv
// Randomised bench for if_prefetch against a queue-level model of fetch, flush and discard.
module tb_if_prefetch;
  import dlx_pkg::*;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_ready    (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ment_t;
  typedef struct { logic [31:0] pc; bit stale; } mfl_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ment_t       mq[$];        // model prefetch queue
  mfl_t        mfl[$];       // model in-flight requests, tagged wrong-path on redirect
  mreq_t       memq[$];      // memory pending responses
  logic [31:0] mpc;
  logic [31:0] consumed[$];
  int          cyc, n_vec, n_err, lat_min, lat_max;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic rdy,
                      input logic redir, input logic [31:0] rpc);
    logic        rv, ereq, ev;
    logic [31:0] rd, eaddr, epc, einstr;
    mfl_t        f;
    int          due;
    @(negedge clk);
    rv = !r && (memq.size() > 0) && (memq[0].due <= cyc);
    rd = rv ? (memq[0].addr ^ 32'hA5A5_0000) : DLX_NOP;
    rst = r; imem_gnt = g; id_ready = rdy; redirect = redir; redirect_pc = rpc;
    imem_rvalid = rv; imem_rdata = rd;
    #1;
    ereq   = !r && (mfl.size() < MAX_OUTST) && ((mq.size() + mfl.size()) < DEPTH);
    eaddr  = r ? RESET_PC : mpc;
    ev     = !r && (mq.size() > 0);
    epc    = ev ? mq[0].pc : 32'h0;
    einstr = ev ? mq[0].instr : 32'h0;
    check("imem_req",    32'(imem_req), 32'(ereq));
    check("imem_addr",   imem_addr, eaddr);
    check("id_valid",    32'(id_valid), 32'(ev));
    check("id_pc",       id_pc, epc);
    check("id_instr",    id_instr, einstr);
    check("id_pc_plus4", id_pc_plus4, epc + 32'd4);
    s_req = imem_req; s_valid = id_valid; s_addr = imem_addr; s_pc = id_pc;
    if (id_valid && rdy && !redir && !r) begin
      consumed.push_back(id_pc);
      $display("cyc %0d consume pc=%h instr=%h", cyc, id_pc, id_instr);
    end
    // Memory: in-order responses, latency lat_min..lat_max, at most one per cycle.
    if (r) begin
      memq.delete();
    end else begin
      if (rv) void'(memq.pop_front());
      if (imem_req && g) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (memq.size() > 0 && due <= memq[$].due) due = memq[$].due + 1;
        memq.push_back('{imem_addr, due});
      end
    end
    // Reference model.
    if (r) begin
      mq.delete(); mfl.delete(); mpc = RESET_PC;
    end else begin
      if (ev && rdy && !redir) void'(mq.pop_front());
      if (rv) begin
        assert (mfl.size() > 0) else $error("protocol: rvalid with nothing outstanding");
        if (mfl.size() > 0) begin
          f = mfl.pop_front();
          if (!f.stale && !redir) mq.push_back('{f.pc, rd});
        end
      end
      if (ereq && g) begin
        mfl.push_back('{mpc, 1'b0});
        mpc = mpc + 32'd4;
      end
      if (redir) begin
        mq.delete();
        foreach (mfl[i]) mfl[i].stale = 1'b1;
        mpc = {rpc[31:2], 2'b00};
      end
    end
    cyc++;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; lat_min = 1; lat_max = 1; mpc = RESET_PC;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = DLX_NOP;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;

    // Streaming with a 1-cycle memory.
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    consumed.delete();
    repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("stream_rate", 32'(consumed.size() >= 12), 32'd1);
    for (int i = 0; i < 4; i++)
      check("stream_pc", (i < consumed.size()) ? consumed[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Stall until full, then drain.
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    consumed.delete();
    repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_req",   32'(s_req), 32'd0);
    check("stall_valid", 32'(s_valid), 32'd1);
    check("stall_head",  s_pc, RESET_PC);
    repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++)
      check("drain_pc", (i < consumed.size()) ? consumed[i] : 32'hDEAD_BEEF, 32'(4 * i));

    // Redirect with two requests outstanding.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 20 && mfl.size() != 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    consumed.delete();
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_addr", s_addr, 32'h0000_0100);
    repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_first_pc", (consumed.size() > 0) ? consumed[0] : 32'hDEAD_BEEF, 32'h0000_0100);

    // Redirect coinciding with a grant and a response.
    lat_min = 1; lat_max = 1;
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    consumed.delete();
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("gr_redir_pc0", (consumed.size() > 0) ? consumed[0] : 32'hDEAD_BEEF, 32'h0000_0200);
    check("gr_redir_pc1", (consumed.size() > 1) ? consumed[1] : 32'hDEAD_BEEF, 32'h0000_0204);

    // Variable latency across the address wrap.
    lat_min = 1; lat_max = 3;
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    consumed.delete();
    repeat (40) step(1'b0, 1'(($urandom % 100) < 60), 1'(($urandom % 100) < 70), 1'b0, 32'h0);
    check("wrap_pc0", (consumed.size() > 0) ? consumed[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
    check("wrap_pc1", (consumed.size() > 1) ? consumed[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    check("wrap_pc2", (consumed.size() > 2) ? consumed[2] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Reset pulse with a full queue.
    lat_min = 1; lat_max = 1;
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("full_valid", 32'(s_valid), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_req",   32'(s_req), 32'd0);
    consumed.delete();
    repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("post_rst_pc", (consumed.size() > 0) ? consumed[0] : 32'hDEAD_BEEF, RESET_PC);

    // Fully random traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 400; i++) begin
      logic r_i, redir_i;
      r_i     = 1'(($urandom % 150) == 0);
      redir_i = 1'(($urandom % 12) == 0);
      step(r_i, 1'(($urandom % 100) < 70), 1'(($urandom % 100) < 70), redir_i, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
